// File: rtl/io_port_unit.sv
// io_port_unit: the I/O port block between the Controller core and the external pins.
// It contains three parts:
//   - an input FIFO with a registered IN read path,
//   - a held output port with a one-cycle strobe,
//   - an edge-triggered, acknowledged interrupt request.
module io_port_unit #(
    parameter int DATA_W   = 16,
    parameter int IN_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    // input port / FIFO
    input  logic [DATA_W-1:0] inPortData,
    input  logic              inPortValid,
    output logic              inPortReady,
    input  logic              rdEn,
    output logic [DATA_W-1:0] rdData,
    output logic              rdValid,
    output logic              inEmpty,
    output logic              inOverflow,
    // output port
    input  logic              wrEn,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] outPortData,
    output logic              outSignalEn,
    // interrupt
    input  logic              interruptSignal,
    input  logic              intAck,
    output logic              intReq
);

    localparam int AW = $clog2(IN_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(IN_DEPTH);

    typedef enum logic {IDLE, PENDING} int_state_e;

    logic [DATA_W-1:0] mem_q [IN_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              ovf_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_en_q;
    logic              int_prev_q;
    int_state_e        int_state_q, int_state_d;

    logic push, pop, int_edge;

    // The flags come from the count that was registered at the previous edge.
    // As a result, a full FIFO refuses a push even while a pop happens in the same cycle.
    assign inPortReady = (count_q != FULL_CNT);
    assign inEmpty     = (count_q == '0);
    assign push        = inPortValid && inPortReady;
    assign pop         = rdEn && !inEmpty;
    assign int_edge    = interruptSignal && !int_prev_q;

    assign rdData      = rd_data_q;
    assign rdValid     = rd_valid_q;
    assign inOverflow  = ovf_q;
    assign outPortData = out_data_q;
    assign outSignalEn = out_en_q;
    assign intReq      = (int_state_q == PENDING);

    // FIFO pointer/count next state; the pointers wrap naturally at IN_DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // Interrupt FSM next state.
    // An edge arriving in the same cycle as an ack keeps the request pending.
    always_comb begin
        int_state_d = int_state_q;
        case (int_state_q)
            IDLE:    if (int_edge)             int_state_d = PENDING;
            PENDING: if (intAck && !int_edge)  int_state_d = IDLE;
            default:                           int_state_d = IDLE;
        endcase
    end

    // FIFO storage writes; the contents need no reset because the count guards every read
    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wr_ptr_q] <= inPortData;
    end

    // Control and datapath registers.
    // During reset, intPrev tracks the pin, so a pin that is already high raises no request.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_en_q    <= 1'b0;
            int_prev_q  <= interruptSignal;
            int_state_q <= IDLE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= pop;
            if (pop) rd_data_q <= mem_q[rd_ptr_q];
            if (inPortValid && !inPortReady) ovf_q <= 1'b1;
            out_en_q    <= wrEn;
            if (wrEn) out_data_q <= wrData;
            int_prev_q  <= interruptSignal;
            int_state_q <= int_state_d;
        end
    end

endmodule
